sending_output_image: RTL and testbench

- Parallel-to-serial transmitter; the counterpart of the 32-bit-word image receiver.
- Captures one complete 256-bit vector (image or ELM result) in a single cycle.
- Streams it out as 8 consecutive 32-bit words under a valid/ready handshake.
- Sits at the output boundary of the inference engine and drives the external 32-bit bus.

---
 rtl/sending_output_image.sv | 139 +++++++++++++
 tb/tb_sending_output_image.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sending_output_image.sv
`default_nettype none
// ============================================================================
// Module   : sending_output_image
// Purpose  : Parallel-to-serial transmitter. Captures a 256-bit vector in one
//            cycle and streams it out as NUM_WORDS words of WORD_W bits under
//            a valid/ready handshake. Word k is image_256_bit[1+32k:32+32k].
// Options  : WORD_PARITY_EN - adds output 'parity', the XOR reduction of the
//            word on image_32_bit (0 while valid=0).
// Revision : 1.0 - initial release
// ============================================================================
module sending_output_image #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:WORD_W*NUM_WORDS]    image_256_bit,
  input  logic                         load,
  input  logic                         ready,
  output logic [WORD_W-1:0]            image_32_bit,
  output logic                         valid,
  output logic                         busy,
`ifdef WORD_PARITY_EN
  output logic                         parity,
`endif
  output logic                         done
);

  localparam int VEC_W = WORD_W * NUM_WORDS;
  localparam int CNT_W = $clog2(NUM_WORDS) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
`ifdef WORD_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // The current word is always the top slice of the shift register; index 1
  // of the input vector lands in the MSB, so word 0 goes out first.
  assign image_32_bit = shreg_q[VEC_W-1 -: WORD_W];
  assign valid        = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef WORD_PARITY_EN
  assign parity       = parity_q;
`endif

  // State and datapath registers; reset aborts any transfer immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef WORD_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef WORD_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic: capture in IDLE, shift on each accepted word in SEND,
  // single-cycle DONE pulse before returning to IDLE.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    count_d  = count_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef WORD_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shreg_d  = image_256_bit;
          count_d  = '0;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
`ifdef WORD_PARITY_EN
          parity_d = ^image_256_bit[1:WORD_W];
`endif
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (valid_q && ready) begin
          if (count_q == C_LAST) begin
            // Last word accepted: the output word is left as-is, valid drops.
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
`ifdef WORD_PARITY_EN
            parity_d = 1'b0;
`endif
            state_d  = S_DONE;
          end else begin
            shreg_d  = shreg_q << WORD_W;
            count_d  = count_q + CNT_W'(1);
`ifdef WORD_PARITY_EN
            parity_d = ^shreg_q[VEC_W-WORD_W-1 -: WORD_W];
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sending_output_image.sv
`default_nettype none
// ============================================================================
// Module   : tb_sending_output_image
// Purpose  : Directed self-checking bench for sending_output_image. Expected
//            words come from hand-written vectors; words are reassembled from
//            the serial stream and compared against the original vector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sending_output_image;

  logic         clock;
  logic         reset;
  logic [255:0] image;
  logic         load;
  logic         ready;
  logic [31:0]  word;
  logic         valid;
  logic         busy;
  logic         done;
`ifdef WORD_PARITY_EN
  logic         parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] VEC_A = {32'd0, 32'd1, 32'd2, 32'd3,
                                    32'd4, 32'd5, 32'd6, 32'd7};
  localparam logic [255:0] VEC_B = {32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003,
                                    32'h5555_0004, 32'h6666_0005, 32'h7777_0006, 32'h8888_0007};
  localparam logic [255:0] VEC_L = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98,
                                    32'h76543210, 32'hCAFEF00D, 32'h12345678, 32'hA5A5A5A5};

  sending_output_image #(.WORD_W(32), .NUM_WORDS(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .image_256_bit (image),
    .load          (load),
    .ready         (ready),
    .image_32_bit  (word),
    .valid         (valid),
    .busy          (busy),
`ifdef WORD_PARITY_EN
    .parity        (parity),
`endif
    .done          (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] wexp(input logic [255:0] v, input int k);
    return v[255 - 32*k -: 32];
  endfunction

  // Drives ready (full rate or 1,0,0,1,... backpressure), checks every word
  // while it is presented, reassembles the accepted words, and checks the
  // done pulse. Optionally raises load with VEC_B while word 3 is shown.
  task automatic stream(input logic [255:0] v, input bit bp, input bit inject);
    int k;
    int cyc;
    logic [255:0] rx;
    k   = 0;
    cyc = 0;
    rx  = '0;
    while (k < 8 && cyc < 64) begin
      ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (inject && k == 3) begin
        load  = 1'b1;
        image = VEC_B;
      end
      chk("valid_during_send", 256'(valid), 256'(1'b1));
      chk("busy_during_send",  256'(busy),  256'(1'b1));
      chk($sformatf("word%0d", k), 256'(word), 256'(wexp(v, k)));
`ifdef WORD_PARITY_EN
      chk("parity", 256'(parity), 256'(^wexp(v, k)));
`endif
      if (ready && valid) begin
        rx = {rx[223:0], word};
        k++;
      end
      tick();
      cyc++;
    end
    chk("transfer_count", 256'(k), 256'(8));
    if (!bp) chk("full_rate_cycles", 256'(cyc), 256'(8));
    chk("done_pulse", 256'(done), 256'(1'b1));
    chk("busy_falls_with_done", 256'(busy), 256'(1'b0));
    chk("valid_after_last", 256'(valid), 256'(1'b0));
`ifdef WORD_PARITY_EN
    chk("parity_when_idle", 256'(parity), 256'(1'b0));
`endif
    chk("loopback_vector", rx, v);
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    ready = 1'b0;
    image = '0;

    // Reset held three cycles, then idle for ten.
    repeat (3) tick();
    chk("reset_outputs", {valid, busy, done, word}, '0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outputs", {valid, busy, done, word}, '0);
    end

    // Full-rate transfer.
    image = VEC_A;
    load  = 1'b1;
    ready = 1'b1;
    tick();
    load  = 1'b0;
    stream(VEC_A, 1'b0, 1'b0);
    tick();
    chk("done_one_cycle", 256'(done), 256'(1'b0));

    // Backpressure 1,0,0,1,...
    image = VEC_A;
    load  = 1'b1;
    ready = 1'b0;
    tick();
    load  = 1'b0;
    stream(VEC_A, 1'b1, 1'b0);
    tick();
    chk("done_one_cycle_bp", 256'(done), 256'(1'b0));

    // Load while busy: B raised during word 3 of A and held.
    image = VEC_A;
    load  = 1'b1;
    ready = 1'b1;
    tick();
    load  = 1'b0;
    stream(VEC_A, 1'b0, 1'b1);
    tick();
    chk("done_state_ignores_load", {valid, busy, done}, '0);
    tick();
    chk("b_captured_valid", {valid, busy}, 256'(2'b11));
    chk("b_word0", 256'(word), 256'(wexp(VEC_B, 0)));
    load = 1'b0;
    stream(VEC_B, 1'b0, 1'b0);
    tick();

    // Asynchronous reset during word 5.
    image = VEC_A;
    load  = 1'b1;
    ready = 1'b1;
    tick();
    load  = 1'b0;
    repeat (5) tick();
    chk("word5_before_reset", 256'(word), 256'(wexp(VEC_A, 5)));
    #2 reset = 1'b0;
    #1;
    chk("async_reset_drop", {valid, busy, done, word}, '0);
    tick();
    chk("no_done_after_abort", 256'(done), 256'(1'b0));
    reset = 1'b1;
    tick();
    chk("idle_after_abort", {valid, busy, done}, '0);
    image = VEC_B;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    chk("post_reset_word0", 256'(word), 256'(wexp(VEC_B, 0)));
    stream(VEC_B, 1'b0, 1'b0);
    tick();

    // Loopback of a mixed vector.
    image = VEC_L;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    chk("loopback_word0", 256'(word), 256'(32'hDEADBEEF));
`ifdef WORD_PARITY_EN
    chk("parity_deadbeef", 256'(parity), 256'(1'b0));
`endif
    stream(VEC_L, 1'b0, 1'b0);
    tick();
    chk("final_idle", {valid, busy, done}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
